// File: rtl/k2red_pipe.sv
// Five-stage elastic K2-RED reduction for Proth moduli Q = k*2^M + 1 with per-transaction terms.
// Define K2RED_CORRECT_EN for a fully reduced result; otherwise S5 registers C2 lazily.
module k2red_pipe #(
    parameter int W     = 32,
    parameter int M     = 17,
    parameter int LOG_L = 4,
    parameter int TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*W-1:0]       in_a,
    input  logic [W-1:0]         in_q,
    input  logic [3*LOG_L-1:0]   in_l,
    input  logic [2:0]           in_neg,
    input  logic [2:0]           in_ten,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_c,
    output logic [TAG_W-1:0]     out_tag
);
    localparam int SW  = 2*W + 2;
    localparam int AHW = 2*W - M;
    localparam int KSH = W - 1 - M;
    localparam int CW  = 3*LOG_L;

    function automatic logic signed [SW-1:0] mulk(
        input logic signed [SW-1:0] x,
        input logic [CW-1:0]        l,
        input logic [2:0]           neg,
        input logic [2:0]           ten
    );
        logic signed [SW-1:0] acc;
        logic signed [SW-1:0] term;
        acc = x <<< KSH;
        for (int unsigned i = 0; i < 3; i++) begin
            term = x <<< l[i*LOG_L +: LOG_L];
            if (ten[i]) acc = neg[i] ? acc - term : acc + term;
        end
        return acc;
    endfunction

    logic [4:0]            vld;
    logic                  adv;

    logic [AHW-1:0]        ah_s1;
    logic [M-1:0]          al_s1;
    logic signed [SW-1:0]  c1_s2;
    logic signed [SW-1:0]  c1h_s3;
    logic [M-1:0]          c1l_s3;
    logic signed [SW-1:0]  c2_s4;

    logic [CW-1:0]         l_s1, l_s2, l_s3;
    logic [2:0]            neg_s1, neg_s2, neg_s3;
    logic [2:0]            ten_s1, ten_s2, ten_s3;
    logic [W-1:0]          q_s1, q_s2, q_s3, q_s4;
    logic [TAG_W-1:0]      tag_s1, tag_s2, tag_s3, tag_s4;

    logic signed [SW-1:0]  al_x, ah_x, c1l_x;
    logic signed [SW-1:0]  c1_d, c2_d;
    logic [W-1:0]          c5_d;

    // Single global enable: a stalled output freezes the whole pipe, bubbles included.
    assign adv       = !vld[4] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld[4];

    always_comb begin
        al_x  = signed'({{(SW-M){1'b0}}, al_s1});
        ah_x  = signed'({{(SW-AHW){1'b0}}, ah_s1});
        c1l_x = signed'({{(SW-M){1'b0}}, c1l_s3});
        c1_d  = mulk(al_x, l_s1, neg_s1, ten_s1) - ah_x;
        c2_d  = mulk(c1l_x, l_s3, neg_s3, ten_s3) - c1h_s3;
    end

`ifdef K2RED_CORRECT_EN
    logic signed [SW-1:0]  qx;
    always_comb begin
        qx   = signed'({{(SW-W){1'b0}}, q_s4});
        c5_d = c2_s4[W-1:0];
        if (c2_s4 >= qx)
            c5_d = W'(c2_s4 - qx);
        else if (c2_s4[SW-1])
            c5_d = W'(c2_s4 + qx);
    end
`else
    logic unused_bits;
    assign c5_d        = c2_s4[W-1:0];
    assign unused_bits = ^{c2_s4[SW-1:W], q_s4};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld     <= '0;
            out_c   <= '0;
            out_tag <= '0;
        end else if (adv) begin
            vld     <= {vld[3:0], in_valid};
            out_c   <= c5_d;
            out_tag <= tag_s4;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            ah_s1  <= in_a[2*W-1:M];
            al_s1  <= in_a[M-1:0];
            l_s1   <= in_l;
            neg_s1 <= in_neg;
            ten_s1 <= in_ten;
            q_s1   <= in_q;
            tag_s1 <= in_tag;

            c1_s2  <= c1_d;
            l_s2   <= l_s1;
            neg_s2 <= neg_s1;
            ten_s2 <= ten_s1;
            q_s2   <= q_s1;
            tag_s2 <= tag_s1;

            c1h_s3 <= c1_s2 >>> M;
            c1l_s3 <= c1_s2[M-1:0];
            l_s3   <= l_s2;
            neg_s3 <= neg_s2;
            ten_s3 <= ten_s2;
            q_s3   <= q_s2;
            tag_s3 <= tag_s2;

            c2_s4  <= c2_d;
            q_s4   <= q_s3;
            tag_s4 <= tag_s3;
        end
    end
endmodule

// File: tb/tb_k2red_pipe.sv
// Randomized bench for k2red_pipe: arithmetic reference model, in-order scoreboard and stall checks.
// Honours K2RED_CORRECT_EN in the same way as the design.
module tb_k2red_pipe;
    localparam int W     = 32;
    localparam int M     = 17;
    localparam int LOG_L = 4;
    localparam int TAG_W = 8;
    localparam logic [W-1:0] QDEF = 32'h8000_0001;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [2*W-1:0]      in_a;
    logic [W-1:0]        in_q;
    logic [3*LOG_L-1:0]  in_l;
    logic [2:0]          in_neg;
    logic [2:0]          in_ten;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        out_c;
    logic [TAG_W-1:0]    out_tag;

    k2red_pipe #(.W(W), .M(M), .LOG_L(LOG_L), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_q(in_q), .in_l(in_l), .in_neg(in_neg), .in_ten(in_ten), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]     c;
        logic [TAG_W-1:0] tag;
        logic             cong_en;
        logic [63:0]      cong;
        logic [63:0]      q;
    } exp_t;

    exp_t             expq[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    int               n_out    = 0;
    int               cyc      = 0;
    bit               cong_phase = 1'b0;
    bit               prev_stall = 1'b0;
    logic [W-1:0]     prev_c;
    logic [TAG_W-1:0] prev_tag;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    function automatic logic signed [127:0] kval(input logic [3*LOG_L-1:0] l,
                                                 input logic [2:0] neg, input logic [2:0] ten);
        logic signed [127:0] k;
        k = 128'sd1 <<< (W-1-M);
        for (int i = 0; i < 3; i++)
            if (ten[i]) begin
                if (neg[i]) k = k - (128'sd1 <<< l[i*LOG_L +: LOG_L]);
                else        k = k + (128'sd1 <<< l[i*LOG_L +: LOG_L]);
            end
        return k;
    endfunction

    // Reference: the two K2-RED folds written as floor-division arithmetic on wide integers.
    function automatic exp_t mk(input logic [63:0] a, input logic [W-1:0] q,
                                input logic [3*LOG_L-1:0] l, input logic [2:0] neg,
                                input logic [2:0] ten, input logic [TAG_W-1:0] tag, input bit cong_on);
        exp_t e;
        logic signed [127:0] k, p, a128, q128, al, ah, c1, c1l, c1h, c2, r;
        k    = kval(l, neg, ten);
        p    = 128'sd1 <<< M;
        a128 = signed'({64'b0, a});
        q128 = signed'({96'b0, q});
        al   = a128 % p;
        ah   = a128 / p;
        c1   = k*al - ah;
        c1l  = ((c1 % p) + p) % p;
        c1h  = (c1 - c1l) / p;
        c2   = k*c1l - c1h;
`ifdef K2RED_CORRECT_EN
        if (c2 >= q128)      c2 = c2 - q128;
        else if (c2 < 0)     c2 = c2 + q128;
        e.cong_en = cong_on;
`else
        e.cong_en = 1'b0 & cong_on;
`endif
        r      = (k*k*a128) % q128;
        e.c    = c2[W-1:0];
        e.tag  = tag;
        e.cong = r[63:0];
        e.q    = {32'b0, q};
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {63'b0, out_valid}, 64'd1);
                check("stall_c", {32'b0, out_c}, {32'b0, prev_c});
                check("stall_tag", {56'b0, out_tag}, {56'b0, prev_tag});
            end
            check("in_ready", {63'b0, in_ready}, {63'b0, (!out_valid || out_ready)});
            if (out_valid && out_ready) begin
                n_out++;
                if (expq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_out: got out_c %0d, expected no result", out_c);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check("out_c", {32'b0, out_c}, {32'b0, e.c});
                    check("out_tag", {56'b0, out_tag}, {56'b0, e.tag});
                    if (e.cong_en) check("residue", {32'b0, out_c} % e.q, e.cong);
                end
            end
            if (in_valid && in_ready)
                expq.push_back(mk(in_a, in_q, in_l, in_neg, in_ten, in_tag, cong_phase));
            prev_stall = out_valid && !out_ready;
            prev_c     = out_c;
            prev_tag   = out_tag;
        end
    end

    task automatic send();
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        for (int t = 0; t < 64 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready 0 for 64 cycles, expected acceptance");
        end
    endtask

    task automatic set_default(input logic [63:0] a);
        in_a = a; in_q = QDEF; in_l = '0; in_neg = '0; in_ten = '0;
        in_tag = TAG_W'($urandom());
    endtask

    task automatic gen_cfg();
        logic signed [127:0] k, qq;
        bit ok;
        ok = 1'b0;
        k  = 128'sd1 <<< (W-1-M);
        for (int t = 0; t < 64 && !ok; t++) begin
            in_l   = (3*LOG_L)'($urandom());
            in_neg = 3'($urandom());
            in_ten = 3'($urandom());
            k = kval(in_l, in_neg, in_ten);
            if (k > 0 && ((k <<< M) + 1) < (128'sd1 <<< W)) ok = 1'b1;
        end
        if (!ok) begin
            in_ten = '0;
            k = 128'sd1 <<< (W-1-M);
        end
        qq     = (k <<< M) + 1;
        in_q   = qq[W-1:0];
        in_a   = {$urandom(), $urandom()} % ({32'b0, in_q} * {32'b0, in_q});
        in_tag = TAG_W'($urandom());
    endtask

    task automatic run_one(input string nm, input logic [63:0] a, input logic [W-1:0] expc);
        logic [TAG_W-1:0] t;
        int n;
        set_default(a);
        t = in_tag;
        send();
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({nm, "_latency"}, 64'(n), 64'd5);
        check(nm, {32'b0, out_c}, {32'b0, expc});
        check({nm, "_tag"}, {56'b0, out_tag}, {56'b0, t});
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        int n0, c0, w;
        bit acc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_default(64'd0);
        @(posedge clk);
        #1;
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        check("rst_out_c", {32'b0, out_c}, 64'd0);
        check("rst_out_tag", {56'b0, out_tag}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_one("a_one", 64'd1, 32'd268435456);
        run_one("a_2p17", 64'd1 << 17, 32'd2147467265);
`ifdef K2RED_CORRECT_EN
        run_one("a_corr", (64'd1 << 54) + (64'd1 << 17), 32'd1032192);
`else
        run_one("a_lazy", (64'd1 << 54) + (64'd1 << 17), 32'd2148515841);
`endif

        // Back-to-back at full rate with the base modulus.
        cong_phase = 1'b1;
        n0 = n_out;
        c0 = cyc;
        for (int i = 0; i < 64; i++) begin
            set_default({$urandom(), $urandom()} % ({32'b0, QDEF} * {32'b0, QDEF}));
            send();
        end
        check("b2b_accept_cycles", 64'(cyc - c0), 64'd64);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        check("b2b_results", 64'(n_out - n0), 64'd64);
        cong_phase = 1'b0;
        @(posedge clk);
        #1;

        // Random backpressure, random configs and moduli.
        acc = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                gen_cfg();
            end
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        w = 0;
        while (expq.size() != 0 && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("drain", 64'(expq.size()), 64'd0);

        // Reset with three transactions in flight.
        for (int i = 0; i < 3; i++) begin
            gen_cfg();
            send();
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        check("midrst_out_c", {32'b0, out_c}, 64'd0);
        check("midrst_in_ready", {63'b0, in_ready}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_idle", {63'b0, out_valid}, 64'd0);
        end

        run_one("after_rst", 64'd1 << 17, 32'd2147467265);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
